// File: rtl/message_dispatch_pkg.sv
// Shared definitions for the message dispatch block.
//   - Default widths for parsed messages, type codes and per-group counts.
//   - Slot-index type and a helper returning the last valid index of a group.
package message_dispatch_pkg;

    localparam int DEF_MAX_MESSAGE_BITS = 128;
    localparam int DEF_N_TYPE_W         = 4;
    localparam int DEF_CNT_W            = 2;

    localparam int NUM_SLOTS  = 3;
    localparam int SLOT_IDX_W = 2;

    typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

    function automatic slot_idx_t last_index(input slot_idx_t count);
        return count - slot_idx_t'(1);
    endfunction

endpackage

// File: rtl/message_slot_buffer.sv
// Three-entry holding register for one message group plus the slot index
// that selects the message currently being presented.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load                       capture a new group (slots, types, count)
//   advance                    current slot handshaked downstream
//   load_count                 number of valid slots in the new group (1..3)
//   load_data_1..3             parsed messages in slot order
//   load_type_1..3             type code per slot
//   cur_data, cur_type         message/type at the current slot index
//   cur_last                   current slot is the last of the group
module message_slot_buffer
    import message_dispatch_pkg::*;
#(
    parameter int MAX_MESSAGE_BITS = DEF_MAX_MESSAGE_BITS,
    parameter int N_TYPE_W         = DEF_N_TYPE_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        advance,
    input  logic [SLOT_IDX_W-1:0]       load_count,
    input  logic [MAX_MESSAGE_BITS-1:0] load_data_1,
    input  logic [MAX_MESSAGE_BITS-1:0] load_data_2,
    input  logic [MAX_MESSAGE_BITS-1:0] load_data_3,
    input  logic [N_TYPE_W-1:0]         load_type_1,
    input  logic [N_TYPE_W-1:0]         load_type_2,
    input  logic [N_TYPE_W-1:0]         load_type_3,
    output logic [MAX_MESSAGE_BITS-1:0] cur_data,
    output logic [N_TYPE_W-1:0]         cur_type,
    output logic                        cur_last
);

    logic [MAX_MESSAGE_BITS-1:0] data_q [NUM_SLOTS];
    logic [N_TYPE_W-1:0]         type_q [NUM_SLOTS];
    slot_idx_t                   count_q;
    slot_idx_t                   idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                data_q[i] <= '0;
                type_q[i] <= '0;
            end
            count_q <= '0;
            idx_q   <= '0;
        end else if (load) begin
            data_q[0] <= load_data_1;
            data_q[1] <= load_data_2;
            data_q[2] <= load_data_3;
            type_q[0] <= load_type_1;
            type_q[1] <= load_type_2;
            type_q[2] <= load_type_3;
            count_q   <= load_count;
            idx_q     <= '0;
        end else if (advance) begin
            // Park the index at 0 once the group is finished so the next
            // group always starts from slot 1.
            idx_q <= cur_last ? slot_idx_t'(0) : idx_q + slot_idx_t'(1);
        end
    end

    always_comb begin
        cur_data = data_q[0];
        cur_type = type_q[0];
        case (idx_q)
            2'd1: begin
                cur_data = data_q[1];
                cur_type = type_q[1];
            end
            2'd2: begin
                cur_data = data_q[2];
                cur_type = type_q[2];
            end
            default: begin
                cur_data = data_q[0];
                cur_type = type_q[0];
            end
        endcase
    end

    assign cur_last = (idx_q == last_index(count_q));

endmodule

// File: rtl/message_dispatch.sv
// Serialises groups of up to three parsed messages into a single
// valid/ready message stream. Groups offered while a previous group is
// still draining are dropped and counted.
//
//   state | meaning
//   IDLE  | no group held, ready to accept
//   DRAIN | presenting slots of the held group downstream
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   message_en_in                      group valid from parser (no backpressure)
//   message_1_in..message_3_in         parsed messages, slot order
//   N_type_control_m1_in..m3_in        type code per slot
//   message_number_data_in             number of valid slots (0..3)
//   in_ready                           a group can be accepted this cycle
//   msg_valid/msg_data/msg_type/msg_last/msg_ready   output stream
//   overflow_flag                      sticky, a group was dropped
//   drop_count                         dropped groups, saturating
module message_dispatch
    import message_dispatch_pkg::*;
#(
    parameter int MAX_MESSAGE_BITS = DEF_MAX_MESSAGE_BITS,
    parameter int N_TYPE_W         = DEF_N_TYPE_W,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        message_en_in,
    input  logic [MAX_MESSAGE_BITS-1:0] message_1_in,
    input  logic [MAX_MESSAGE_BITS-1:0] message_2_in,
    input  logic [MAX_MESSAGE_BITS-1:0] message_3_in,
    input  logic [N_TYPE_W-1:0]         N_type_control_m1_in,
    input  logic [N_TYPE_W-1:0]         N_type_control_m2_in,
    input  logic [N_TYPE_W-1:0]         N_type_control_m3_in,
    input  logic [CNT_W-1:0]            message_number_data_in,
    output logic                        in_ready,
    output logic                        msg_valid,
    output logic [MAX_MESSAGE_BITS-1:0] msg_data,
    output logic [N_TYPE_W-1:0]         msg_type,
    output logic                        msg_last,
    input  logic                        msg_ready,
    output logic                        overflow_flag,
    output logic [15:0]                 drop_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t    state_q;
    state_t    state_d;
    slot_idx_t count_in;
    logic      accept;
    logic      load;
    logic      drop;
    logic      handshake;
    logic      cur_last;

    // Counts above three can only appear with a widened count field.
    if (CNT_W > SLOT_IDX_W) begin : g_clamp
        assign count_in = (|message_number_data_in[CNT_W-1:SLOT_IDX_W])
                          ? slot_idx_t'(3) : message_number_data_in[SLOT_IDX_W-1:0];
    end else begin : g_direct
        assign count_in = slot_idx_t'(message_number_data_in);
    end

    assign msg_valid = (state_q == DRAIN);
    assign handshake = msg_valid && msg_ready;
    assign msg_last  = msg_valid && cur_last;
    assign in_ready  = (state_q == IDLE) || (handshake && cur_last);
    assign accept    = message_en_in && in_ready;
    assign load      = accept && (count_in != slot_idx_t'(0));
    assign drop      = message_en_in && !in_ready;

    message_slot_buffer #(
        .MAX_MESSAGE_BITS(MAX_MESSAGE_BITS),
        .N_TYPE_W        (N_TYPE_W)
    ) u_slot_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .advance    (handshake),
        .load_count (count_in),
        .load_data_1(message_1_in),
        .load_data_2(message_2_in),
        .load_data_3(message_3_in),
        .load_type_1(N_type_control_m1_in),
        .load_type_2(N_type_control_m2_in),
        .load_type_3(N_type_control_m3_in),
        .cur_data   (msg_data),
        .cur_type   (msg_type),
        .cur_last   (cur_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) state_d = DRAIN;
            end
            DRAIN: begin
                // A group accepted on the final handshake keeps us in DRAIN,
                // giving a bubble-free handover.
                if (handshake && cur_last && !load) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_flag <= 1'b0;
            drop_count    <= '0;
        end else if (drop) begin
            overflow_flag <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_message_dispatch.sv
module tb_message_dispatch;

    localparam int MB = 128;
    localparam int TW = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic          last;
        logic [TW-1:0] mtype;
        logic [MB-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          message_en_in;
    logic [MB-1:0] message_1_in, message_2_in, message_3_in;
    logic [TW-1:0] N_type_control_m1_in, N_type_control_m2_in, N_type_control_m3_in;
    logic [CW-1:0] message_number_data_in;
    logic          in_ready;
    logic          msg_valid;
    logic [MB-1:0] msg_data;
    logic [TW-1:0] msg_type;
    logic          msg_last;
    logic          msg_ready;
    logic          overflow_flag;
    logic [15:0]   drop_count;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    message_dispatch #(
        .MAX_MESSAGE_BITS(MB),
        .N_TYPE_W        (TW),
        .CNT_W           (CW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .message_en_in         (message_en_in),
        .message_1_in          (message_1_in),
        .message_2_in          (message_2_in),
        .message_3_in          (message_3_in),
        .N_type_control_m1_in  (N_type_control_m1_in),
        .N_type_control_m2_in  (N_type_control_m2_in),
        .N_type_control_m3_in  (N_type_control_m3_in),
        .message_number_data_in(message_number_data_in),
        .in_ready              (in_ready),
        .msg_valid             (msg_valid),
        .msg_data              (msg_data),
        .msg_type              (msg_type),
        .msg_last              (msg_last),
        .msg_ready             (msg_ready),
        .overflow_flag         (overflow_flag),
        .drop_count            (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [MB-1:0] mk_data(input int g, input int s);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(g << 4) | 32'(s);
        return {w ^ 32'h1111_1111, w ^ 32'h2222_2222, w ^ 32'h4444_4444, w};
    endfunction

    function automatic logic [TW-1:0] mk_type(input int g, input int s);
        return TW'((g * 3 + s + 1) & 15);
    endfunction

    task automatic check(input string tag, input logic [MB+TW:0] obs, input logic [MB+TW:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every downstream handshake must match the oldest expected message.
    always @(negedge clk) begin
        if (rst_n && msg_valid && msg_ready) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected observed=%0h expected=none", msg_data);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_msg", {msg_last, msg_type, msg_data}, {e.last, e.mtype, e.data});
            end
        end
    end

    task automatic idle();
        message_en_in          = 1'b0;
        message_1_in           = {$urandom(), $urandom(), $urandom(), $urandom()};
        message_2_in           = {$urandom(), $urandom(), $urandom(), $urandom()};
        message_3_in           = {$urandom(), $urandom(), $urandom(), $urandom()};
        N_type_control_m1_in   = TW'($urandom());
        N_type_control_m2_in   = TW'($urandom());
        N_type_control_m3_in   = TW'($urandom());
        message_number_data_in = CW'($urandom_range(1, 3));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_group(input int g, input int cnt, input logic exp_acc);
        message_en_in          = 1'b1;
        message_1_in           = mk_data(g, 0);
        message_2_in           = mk_data(g, 1);
        message_3_in           = mk_data(g, 2);
        N_type_control_m1_in   = mk_type(g, 0);
        N_type_control_m2_in   = mk_type(g, 1);
        N_type_control_m3_in   = mk_type(g, 2);
        message_number_data_in = CW'(cnt);
        check($sformatf("in_ready_g%0d", g), {{(MB+TW){1'b0}}, in_ready}, {{(MB+TW){1'b0}}, exp_acc});
        if (exp_acc) begin
            for (int s = 0; s < cnt; s++) begin
                exp_t e;
                e.last  = (s == cnt - 1);
                e.mtype = mk_type(g, s);
                e.data  = mk_data(g, s);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        message_en_in = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, {{(MB+TW){1'b0}}, obs}, {{(MB+TW){1'b0}}, exp});
    endtask

    initial begin
        rst_n                  = 1'b0;
        msg_ready              = 1'b1;
        message_en_in          = 1'b0;
        message_1_in           = '0;
        message_2_in           = '0;
        message_3_in           = '0;
        N_type_control_m1_in   = '0;
        N_type_control_m2_in   = '0;
        N_type_control_m3_in   = '0;
        message_number_data_in = '0;
        #1;
        chk1("rst_valid", msg_valid, 1'b0);
        chk1("rst_last", msg_last, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_overflow", overflow_flag, 1'b0);
        check("rst_data", {5'b0, msg_data}, '0);
        check("rst_type", {{(MB+1){1'b0}}, msg_type}, '0);
        check("rst_drop_count", {{(MB+TW-15){1'b0}}, drop_count}, '0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single group of three, ready always high.
        drive_group(1, 3, 1'b1);
        chk1("g1_t1_valid", msg_valid, 1'b1);
        chk1("g1_t1_last", msg_last, 1'b0);
        idle();
        chk1("g1_t2_valid", msg_valid, 1'b1);
        chk1("g1_t2_last", msg_last, 1'b0);
        idle();
        chk1("g1_t3_valid", msg_valid, 1'b1);
        chk1("g1_t3_last", msg_last, 1'b1);
        chk1("g1_t3_in_ready", in_ready, 1'b1);
        idle();
        chk1("g1_t4_valid", msg_valid, 1'b0);

        // Back-to-back groups: count 2, then count 1 on the last handshake.
        drive_group(2, 2, 1'b1);
        chk1("g2_t1_last", msg_last, 1'b0);
        idle();
        chk1("g2_t2_last", msg_last, 1'b1);
        drive_group(3, 1, 1'b1);
        chk1("g3_nobubble_valid", msg_valid, 1'b1);
        chk1("g3_last", msg_last, 1'b1);
        idle();
        chk1("g3_after_valid", msg_valid, 1'b0);

        // Backpressure: slot 1 held for four cycles.
        msg_ready = 1'b0;
        drive_group(4, 2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("g4_hold%0d_valid", i), msg_valid, 1'b1);
            check($sformatf("g4_hold%0d_msg", i), {msg_last, msg_type, msg_data},
                  {1'b0, mk_type(4, 0), mk_data(4, 0)});
            if (i < 3) idle();
        end
        msg_ready = 1'b1;
        idle();
        chk1("g4_slot2_last", msg_last, 1'b1);
        idle();
        chk1("g4_done_valid", msg_valid, 1'b0);

        // Group arriving mid-drain is dropped.
        drive_group(5, 3, 1'b1);
        drive_group(6, 2, 1'b0);
        chk1("drop_overflow", overflow_flag, 1'b1);
        check("drop_count1", {{(MB+TW-15){1'b0}}, drop_count}, {{(MB+TW-15){1'b0}}, 16'd1});
        check("drop_cur_msg", {msg_last, msg_type, msg_data}, {1'b0, mk_type(5, 1), mk_data(5, 1)});
        idle();
        idle();
        chk1("drop_done_valid", msg_valid, 1'b0);
        chk1("drop_done_in_ready", in_ready, 1'b1);

        // Count zero is a no-op.
        drive_group(7, 0, 1'b1);
        chk1("cnt0_valid", msg_valid, 1'b0);
        chk1("cnt0_in_ready", in_ready, 1'b1);
        idle();
        chk1("cnt0_valid2", msg_valid, 1'b0);
        check("cnt0_drop_count", {{(MB+TW-15){1'b0}}, drop_count}, {{(MB+TW-15){1'b0}}, 16'd1});

        // Reset in the middle of a count-3 drain.
        drive_group(8, 3, 1'b1);
        idle();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk1("mrst_valid", msg_valid, 1'b0);
        chk1("mrst_last", msg_last, 1'b0);
        chk1("mrst_overflow", overflow_flag, 1'b0);
        chk1("mrst_in_ready", in_ready, 1'b1);
        check("mrst_data", {5'b0, msg_data}, '0);
        check("mrst_type", {{(MB+1){1'b0}}, msg_type}, '0);
        check("mrst_drop_count", {{(MB+TW-15){1'b0}}, drop_count}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk1($sformatf("mrst_post%0d_valid", i), msg_valid, 1'b0);
        end

        check("sb_empty", {{(MB+TW-31){1'b0}}, 32'(exp_q.size())}, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
